// File: rtl/payload_engine_ctrl_if.sv
// ----------------------------------------------------------------------------
// payload_engine_ctrl_if
//   Bundles the two handshaked channels of payload_engine_ctrl:
//     - payload byte stream from the packet payload extractor (s_*)
//     - per-packet result channel (res_*)
//   Modports:
//     master : the surrounding system (drives bytes, consumes results)
//     slave  : payload_engine_ctrl (accepts bytes, produces results)
//   Parameters NUM_ENG / LEN_W must match the controller instance.
// ----------------------------------------------------------------------------
interface payload_engine_ctrl_if #(
    parameter int NUM_ENG = 16,
    parameter int LEN_W   = 16
) ();
    // payload byte stream
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         s_data;
    logic               s_sop;
    logic               s_eop;

    // per-packet result
    logic               res_valid;
    logic               res_ready;
    logic [NUM_ENG-1:0] res_match;
    logic [LEN_W-1:0]   res_len;
    logic               res_trunc;
    logic               res_timeout;

    modport master (
        output s_valid, s_data, s_sop, s_eop, res_ready,
        input  s_ready, res_valid, res_match, res_len, res_trunc, res_timeout
    );

    modport slave (
        input  s_valid, s_data, s_sop, s_eop, res_ready,
        output s_ready, res_valid, res_match, res_len, res_trunc, res_timeout
    );
endinterface

// File: rtl/payload_engine_ctrl.sv
// ----------------------------------------------------------------------------
// payload_engine_ctrl
//   Feeds one packet payload at a time into a bank of NUM_ENG regex engines
//   that share a single byte stream. Per packet: pulse eng_sod to clear the
//   engines, issue one eng_en per forwarded byte, issue DRAIN_CYC drain
//   enables with eng_char_vld=0, snapshot the sticky eng_match bits and
//   hand back a result over a valid/ready channel.
//
//   Ports
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     bus           payload_engine_ctrl_if.slave: s_* byte stream in,
//                   res_* result out
//     eng_sod       engine clear, registered, high during reset
//     eng_en        engine clock-enable, registered
//     eng_char      byte to the char decoder, registered
//     eng_char_vld  0 makes the decoder drive all in_* lines low
//     eng_match     sticky engine match outputs
//     busy          controller is not IDLE
//
//   Optional feature: define PE_CTRL_TIMEOUT_EN to force a drain after
//   TIMEOUT consecutive idle cycles inside a packet (res_timeout=1).
//   Without it the controller waits indefinitely for eop.
// ----------------------------------------------------------------------------
module payload_engine_ctrl #(
    parameter int NUM_ENG   = 16,
    parameter int LEN_W     = 16,
    parameter int MAX_LEN   = 1500,
    parameter int DRAIN_CYC = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    payload_engine_ctrl_if.slave bus,
    output logic                 eng_sod,
    output logic                 eng_en,
    output logic [7:0]           eng_char,
    output logic                 eng_char_vld,
    input  logic [NUM_ENG-1:0]   eng_match,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

    state_t            state, state_nxt;
    logic              s_ready_c;
    logic              accept;
    logic              drain_done;
    logic              stall_hit;
    logic [DCNT_W-1:0] dcnt;
    logic [LEN_W-1:0]  len;
    logic              trunc;
    logic              tout;

    assign accept = bus.s_valid & s_ready_c;
    assign busy   = (state != IDLE);
    assign bus.s_ready = s_ready_c;

    // DRAIN lasts DRAIN_CYC+1 cycles: DRAIN_CYC enable cycles, then one
    // cycle in which the match vector is captured, so the last drain
    // enable has been seen by the engines before the snapshot.
    assign drain_done = (state == DRAIN) && (dcnt == DCNT_W'(DRAIN_CYC));

`ifdef PE_CTRL_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    // s_ready is 1 throughout STREAM, so "no accept" == "s_valid low".
    assign stall_hit = (state == STREAM) && !bus.s_valid &&
                       (tcnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (state != STREAM || accept)
            tcnt <= '0;
        else
            tcnt <= tcnt + TCNT_W'(1);
    end
`else
    assign stall_hit = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next state / s_ready ----------------
    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        case (state)
            IDLE: begin
                // stray bytes outside a packet are swallowed; a sop byte is
                // held off until the engines have been cleared
                s_ready_c = bus.s_valid & ~bus.s_sop;
                if (bus.s_valid && bus.s_sop) state_nxt = CLEAR;
            end
            CLEAR:  state_nxt = STREAM;
            STREAM: begin
                s_ready_c = 1'b1;
                if ((bus.s_valid && bus.s_eop) || stall_hit) state_nxt = DRAIN;
            end
            DRAIN:  if (drain_done) state_nxt = RESULT;
            RESULT: if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- engine drive / packet bookkeeping ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_sod         <= 1'b1;
            eng_en          <= 1'b0;
            eng_char        <= 8'h00;
            eng_char_vld    <= 1'b0;
            len             <= '0;
            trunc           <= 1'b0;
            tout            <= 1'b0;
            dcnt            <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_match   <= '0;
            bus.res_len     <= '0;
            bus.res_trunc   <= 1'b0;
            bus.res_timeout <= 1'b0;
        end else begin
            eng_sod      <= (state == CLEAR);
            eng_en       <= 1'b0;
            eng_char_vld <= 1'b0;
            case (state)
                CLEAR: begin
                    len   <= '0;
                    trunc <= 1'b0;
                    tout  <= 1'b0;
                    dcnt  <= '0;
                end
                STREAM: begin
                    if (accept) begin
                        if (len < LEN_W'(MAX_LEN)) begin
                            eng_en       <= 1'b1;
                            eng_char     <= bus.s_data;
                            eng_char_vld <= 1'b1;
                            len          <= len + LEN_W'(1);
                        end else begin
                            // over-length bytes are consumed but not forwarded
                            trunc <= 1'b1;
                        end
                    end
                    if (stall_hit) tout <= 1'b1;
                end
                DRAIN: begin
                    if (!drain_done) begin
                        eng_en   <= 1'b1;
                        eng_char <= 8'h00;
                        dcnt     <= dcnt + DCNT_W'(1);
                    end else begin
                        bus.res_match   <= eng_match;
                        bus.res_len     <= len;
                        bus.res_trunc   <= trunc;
                        bus.res_timeout <= tout;
                        bus.res_valid   <= 1'b1;
                    end
                end
                RESULT: if (bus.res_ready) bus.res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
module tb_payload_engine_ctrl;

    localparam int NE = 16;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // instance A: default length limit, TIMEOUT=8
    // instance B: MAX_LEN=4 for the truncation case
    payload_engine_ctrl_if #(.NUM_ENG(NE), .LEN_W(LW)) a_if ();
    payload_engine_ctrl_if #(.NUM_ENG(NE), .LEN_W(LW)) b_if ();

    logic          a_sod, a_en, a_vld, a_busy;
    logic [7:0]    a_char;
    logic [NE-1:0] a_match;
    logic          b_sod, b_en, b_vld, b_busy;
    logic [7:0]    b_char;
    logic [NE-1:0] b_match;

    payload_engine_ctrl #(.NUM_ENG(NE), .LEN_W(LW), .MAX_LEN(1500), .DRAIN_CYC(2), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if),
        .eng_sod(a_sod), .eng_en(a_en), .eng_char(a_char), .eng_char_vld(a_vld),
        .eng_match(a_match), .busy(a_busy)
    );

    payload_engine_ctrl #(.NUM_ENG(NE), .LEN_W(LW), .MAX_LEN(4), .DRAIN_CYC(2), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if),
        .eng_sod(b_sod), .eng_en(b_en), .eng_char(b_char), .eng_char_vld(b_vld),
        .eng_match(b_match), .busy(b_busy)
    );

    // engine-side activity counters, sampled on the falling edge
    int a_sod_cnt = 0, a_data_cnt = 0, a_drain_cnt = 0;
    int b_data_cnt = 0, b_drain_cnt = 0;
    logic [7:0] a_chars[$];

    always @(negedge clk) begin
        if (a_sod) a_sod_cnt <= a_sod_cnt + 1;
        if (a_en && a_vld) begin
            a_data_cnt <= a_data_cnt + 1;
            a_chars.push_back(a_char);
        end
        if (a_en && !a_vld) a_drain_cnt <= a_drain_cnt + 1;
        if (b_en && b_vld)  b_data_cnt  <= b_data_cnt + 1;
        if (b_en && !b_vld) b_drain_cnt <= b_drain_cnt + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // all stimulus is applied and sampled 2ns after the falling edge
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic rdy(input bit b);
        return b ? b_if.s_ready : a_if.s_ready;
    endfunction

    function automatic logic rvld(input bit b);
        return b ? b_if.res_valid : a_if.res_valid;
    endfunction

    // present one byte, wait for the accept; t_acc is the accept cycle
    task automatic push(input bit b, input logic [7:0] d, input logic sop, input logic eop,
                        output int t_acc, output bit ok);
        int w = 0;
        if (b) begin b_if.s_valid = 1'b1; b_if.s_data = d; b_if.s_sop = sop; b_if.s_eop = eop; end
        else   begin a_if.s_valid = 1'b1; a_if.s_data = d; a_if.s_sop = sop; a_if.s_eop = eop; end
        #1;
        while (!rdy(b) && w < 40) begin tick(); #1; w++; end
        ok = rdy(b);
        t_acc = cyc;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL push_accept: byte %h never accepted within 40 cycles", d);
        end
        tick();
        if (b) begin b_if.s_valid = 1'b0; b_if.s_sop = 1'b0; b_if.s_eop = 1'b0; end
        else   begin a_if.s_valid = 1'b0; a_if.s_sop = 1'b0; a_if.s_eop = 1'b0; end
    endtask

    task automatic wait_res(input bit b, output int t_v);
        int w = 0;
        while (!rvld(b) && w < 60) begin tick(); w++; end
        t_v = cyc;
    endtask

    task automatic ack(input bit b);
        if (b) b_if.res_ready = 1'b1; else a_if.res_ready = 1'b1;
        tick();
        if (b) b_if.res_ready = 1'b0; else a_if.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) tick();
        n_checks++; if (a_sod !== 1'b1)          begin n_fail++; $display("FAIL reset_sod: got %b expected 1", a_sod); end
        n_checks++; if (a_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", a_if.res_valid); end
        n_checks++; if (a_if.s_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", a_if.s_ready); end
        n_checks++; if (a_en !== 1'b0 || a_vld !== 1'b0 || a_busy !== 1'b0)
                        begin n_fail++; $display("FAIL reset_en_vld_busy: got %b%b%b expected 000", a_en, a_vld, a_busy); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_sod !== 1'b1) begin n_fail++; $display("FAIL release_sod_hold: got %b expected 1", a_sod); end
        tick();
        n_checks++; if (a_sod !== 1'b0) begin n_fail++; $display("FAIL release_sod_drop: got %b expected 0", a_sod); end
    endtask

    task automatic test_single();
        int t, tv, s0, d0, r0, q0;
        bit ok;
        s0 = a_sod_cnt; d0 = a_data_cnt; r0 = a_drain_cnt; q0 = a_chars.size();
        push(1'b0, 8'h3F, 1'b1, 1'b1, t, ok);
        wait_res(1'b0, tv);
        n_checks++; if (tv !== t + 4) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", tv, t + 4); end
        n_checks++; if (a_if.res_len !== 16'd1) begin n_fail++; $display("FAIL single_len: got %0d expected 1", a_if.res_len); end
        n_checks++; if (a_sod_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_sod_pulses: got %0d expected 1", a_sod_cnt - s0); end
        n_checks++; if (a_data_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_data_en: got %0d expected 1", a_data_cnt - d0); end
        n_checks++; if (a_drain_cnt - r0 !== 2) begin n_fail++; $display("FAIL single_drain_en: got %0d expected 2", a_drain_cnt - r0); end
        n_checks++; if (a_chars.size() <= q0 || a_chars[q0] !== 8'h3F)
                        begin n_fail++; $display("FAIL single_char: got %0d chars expected one 3f", a_chars.size() - q0); end
        n_checks++; if (a_if.res_trunc !== 1'b0 || a_if.res_timeout !== 1'b0)
                        begin n_fail++; $display("FAIL single_flags: got %b%b expected 00", a_if.res_trunc, a_if.res_timeout); end
        ack(1'b0);
        n_checks++; if (a_if.res_valid !== 1'b0 || a_busy !== 1'b0)
                        begin n_fail++; $display("FAIL single_ack: got valid %b busy %b expected 0 0", a_if.res_valid, a_busy); end
    endtask

    task automatic test_ten_hold();
        int t, tv, q0;
        bit ok, good, stable;
        q0 = a_chars.size();
        for (int i = 0; i < 10; i++)
            push(1'b0, 8'h10 + 8'(i), (i == 0 || i == 5), (i == 9), t, ok);
        // now in DRAIN: present the match bits the engines would report
        a_match = 16'h0021;
        wait_res(1'b0, tv);
        n_checks++; if (tv !== t + 4) begin n_fail++; $display("FAIL ten_latency: got cycle %0d expected %0d", tv, t + 4); end
        n_checks++; if (a_if.res_match !== 16'h0021) begin n_fail++; $display("FAIL ten_match: got %h expected 0021", a_if.res_match); end
        n_checks++; if (a_if.res_len !== 16'd10) begin n_fail++; $display("FAIL ten_len: got %0d expected 10", a_if.res_len); end
        good = (a_chars.size() - q0 == 10);
        for (int i = 0; i < 10; i++)
            if (good && a_chars[q0 + i] !== 8'h10 + 8'(i)) good = 1'b0;
        n_checks++; if (!good) begin n_fail++; $display("FAIL ten_chars: got %0d chars expected 10..19 in order", a_chars.size() - q0); end
        // engines change underneath; the result must stay frozen
        a_match = 16'h00FF;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (a_if.res_valid !== 1'b1 || a_if.res_match !== 16'h0021 || a_if.res_len !== 16'd10 ||
                a_if.res_trunc !== 1'b0 || a_busy !== 1'b1) stable = 1'b0;
        end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL ten_hold: got valid %b match %h expected 1 0021", a_if.res_valid, a_if.res_match); end
        ack(1'b0);
        a_match = '0;
        n_checks++; if (a_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL ten_ack: got %b expected 0", a_if.res_valid); end
    endtask

    task automatic test_trunc();
        int t, tv, acc, d0, r0;
        bit ok;
        acc = 0; d0 = b_data_cnt; r0 = b_drain_cnt;
        for (int i = 0; i < 7; i++) begin
            push(1'b1, 8'h50 + 8'(i), (i == 0), (i == 6), t, ok);
            if (ok) acc++;
        end
        wait_res(1'b1, tv);
        n_checks++; if (acc !== 7) begin n_fail++; $display("FAIL trunc_accepts: got %0d expected 7", acc); end
        n_checks++; if (b_data_cnt - d0 !== 4) begin n_fail++; $display("FAIL trunc_data_en: got %0d expected 4", b_data_cnt - d0); end
        n_checks++; if (b_drain_cnt - r0 !== 2) begin n_fail++; $display("FAIL trunc_drain_en: got %0d expected 2", b_drain_cnt - r0); end
        n_checks++; if (b_if.res_valid !== 1'b1 || b_if.res_len !== 16'd4)
                        begin n_fail++; $display("FAIL trunc_len: got valid %b len %0d expected 1 4", b_if.res_valid, b_if.res_len); end
        n_checks++; if (b_if.res_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag: got %b expected 1", b_if.res_trunc); end
        ack(1'b1);
    endtask

    task automatic test_stray();
        int t, c0, s0, d0, r0;
        bit ok, immediate;
        s0 = a_sod_cnt; d0 = a_data_cnt; r0 = a_drain_cnt;
        immediate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            push(1'b0, 8'hAA, 1'b0, 1'b0, t, ok);
            if (!ok || t !== c0) immediate = 1'b0;
        end
        repeat (5) tick();
        n_checks++; if (!immediate) begin n_fail++; $display("FAIL stray_consumed: got a delayed accept expected same-cycle"); end
        n_checks++; if (a_sod_cnt - s0 !== 0 || a_data_cnt - d0 !== 0 || a_drain_cnt - r0 !== 0)
                        begin n_fail++; $display("FAIL stray_engine: got sod %0d en %0d drain %0d expected 0 0 0",
                                                 a_sod_cnt - s0, a_data_cnt - d0, a_drain_cnt - r0); end
        n_checks++; if (a_if.res_valid !== 1'b0 || a_busy !== 1'b0)
                        begin n_fail++; $display("FAIL stray_result: got valid %b busy %b expected 0 0", a_if.res_valid, a_busy); end
    endtask

    task automatic test_timeout();
        int t, tv;
        bit ok;
        push(1'b0, 8'h01, 1'b1, 1'b0, t, ok);
        push(1'b0, 8'h02, 1'b0, 1'b0, t, ok);
`ifdef PE_CTRL_TIMEOUT_EN
        // 8 idle cycles -> DRAIN, then the usual DRAIN_CYC+1 to the result
        wait_res(1'b0, tv);
        n_checks++; if (tv !== t + 12) begin n_fail++; $display("FAIL timeout_latency: got cycle %0d expected %0d", tv, t + 12); end
        n_checks++; if (a_if.res_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b expected 1", a_if.res_timeout); end
        n_checks++; if (a_if.res_len !== 16'd2) begin n_fail++; $display("FAIL timeout_len: got %0d expected 2", a_if.res_len); end
        ack(1'b0);
`else
        repeat (30) tick();
        n_checks++; if (a_if.res_valid !== 1'b0 || a_busy !== 1'b1 || a_if.s_ready !== 1'b1)
                        begin n_fail++; $display("FAIL notimeout_stream: got valid %b busy %b ready %b expected 0 1 1",
                                                 a_if.res_valid, a_busy, a_if.s_ready); end
        push(1'b0, 8'h03, 1'b0, 1'b1, t, ok);
        wait_res(1'b0, tv);
        n_checks++; if (tv !== t + 4) begin n_fail++; $display("FAIL notimeout_latency: got cycle %0d expected %0d", tv, t + 4); end
        n_checks++; if (a_if.res_len !== 16'd3 || a_if.res_timeout !== 1'b0)
                        begin n_fail++; $display("FAIL notimeout_res: got len %0d tout %b expected 3 0", a_if.res_len, a_if.res_timeout); end
        ack(1'b0);
`endif
        n_checks++; if (a_if.res_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_ack: got %b expected 0", a_if.res_valid); end
    endtask

    task automatic test_mid_reset();
        int t, tv;
        bit ok;
        push(1'b0, 8'h77, 1'b1, 1'b0, t, ok);
        push(1'b0, 8'h78, 1'b0, 1'b0, t, ok);
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_sod !== 1'b1 || a_en !== 1'b0 || a_busy !== 1'b0 || a_if.res_valid !== 1'b0)
                        begin n_fail++; $display("FAIL midrst_state: got sod %b en %b busy %b valid %b expected 1 0 0 0",
                                                 a_sod, a_en, a_busy, a_if.res_valid); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push(1'b0, 8'h3F, 1'b1, 1'b1, t, ok);
        wait_res(1'b0, tv);
        n_checks++; if (tv !== t + 4 || a_if.res_len !== 16'd1)
                        begin n_fail++; $display("FAIL midrst_next: got cycle %0d len %0d expected %0d 1", tv, a_if.res_len, t + 4); end
        ack(1'b0);
    endtask

    initial begin
        a_if.s_valid = 1'b0; a_if.s_data = 8'h00; a_if.s_sop = 1'b0; a_if.s_eop = 1'b0; a_if.res_ready = 1'b0;
        b_if.s_valid = 1'b0; b_if.s_data = 8'h00; b_if.s_sop = 1'b0; b_if.s_eop = 1'b0; b_if.res_ready = 1'b0;
        a_match = '0;
        b_match = '0;
        test_reset();
        test_single();
        test_ten_hold();
        test_trunc();
        test_stray();
        test_timeout();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
